// File: rtl/instr_fetch_if.sv
// Instruction-memory request/acknowledge bus between instr_fetch (master) and memory (slave).
interface instr_fetch_if;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          req;
    logic [AW-1:0] addr;
    logic          ack;
    logic [DW-1:0] rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: IDLE/REQ/HOLD fetch FSM with JR > jump > branch > sequential next-PC.
// Define IFETCH_PERF_CNT_EN to enable the completed-fetch counter on instr_count.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic          clk,
    input  logic          reset,
    instr_fetch_if.master imem,
    output logic [31:0]   instr,
    output logic          instr_valid,
    output logic [31:0]   pc,
    output logic [31:0]   pc_plus4,
    input  logic          stall,
    input  logic          dobranch,
    input  logic          dojump,
    input  logic [31:0]   jr_target,
    output logic [31:0]   instr_count
);
    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

    state_t          state;
    logic            is_jr;
    logic [XLEN-1:0] br_offset;
    logic [XLEN-1:0] next_pc;
    logic            unused_jr_low;

    assign imem.addr     = pc;
    assign is_jr         = (instr[31:26] == 6'b000000) && (instr[5:0] == 6'b001000);
    assign br_offset     = XLEN'({{14{instr[15]}}, instr[15:0], 2'b00});
    // jr_target is word-aligned by truncation, so its low bits never matter
    assign unused_jr_low = ^jr_target[1:0];

    // Redirect priority: JR, then absolute jump, then taken branch, else fall through
    always_comb begin
        next_pc = pc_plus4;
        if (is_jr) begin
            next_pc = {jr_target[31:2], 2'b00};
        end else if (dojump) begin
            next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
        end else if (dobranch) begin
            next_pc = pc_plus4 + br_offset;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= RESET_PC_ALIGNED;
            pc_plus4    <= RESET_PC_ALIGNED + 32'd4;
            instr       <= '0;
            instr_valid <= 1'b0;
            imem.req    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state    <= REQ;
                    imem.req <= 1'b1;
                end
                REQ: begin
                    if (imem.ack) begin
                        instr       <= imem.rdata;
                        state       <= HOLD;
                        imem.req    <= 1'b0;
                        instr_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        pc          <= next_pc;
                        pc_plus4    <= next_pc + 32'd4;
                        state       <= REQ;
                        imem.req    <= 1'b1;
                        instr_valid <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    imem.req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef IFETCH_PERF_CNT_EN
    // Counts every accepted instruction word, wrapping at 2^32
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_count <= '0;
        end else if (state == REQ && imem.ack) begin
            instr_count <= instr_count + 32'd1;
        end
    end
`else
    assign instr_count = '0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: driver plays memory + decoder, monitor checks every DUT output.
module tb_instr_fetch;
    localparam logic [31:0] RESET_PC = 32'h0040_0000;

    typedef struct {
        logic [31:0] word;
        logic [31:0] pc;
        logic [31:0] cnt;
        int          run;
    } fetch_exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr, pc, pc_plus4, jr_target, instr_count;
    logic        instr_valid, stall, dobranch, dojump;

    instr_fetch_if imem ();

    instr_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk        (clk),
        .reset      (reset),
        .imem       (imem),
        .instr      (instr),
        .instr_valid(instr_valid),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .stall      (stall),
        .dobranch   (dobranch),
        .dojump     (dojump),
        .jr_target  (jr_target),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_addr_q[$];
    fetch_exp_t  exp_fetch_q[$];
    logic [31:0] model_pc;
    logic [31:0] model_cnt;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference next-PC: decoder-level rules written as plain 32-bit arithmetic
    function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [31:0] w,
                                             input bit db, input bit dj, input logic [31:0] jrt);
        logic [31:0] seq;
        int          off;
        seq = cur + 32'd4;
        off = int'($signed(w[15:0])) * 4;
        if (w[31:26] == 6'd0 && w[5:0] == 6'd8) return jrt & 32'hFFFF_FFFC;
        if (dj) return (seq & 32'hF000_0000) | ((w & 32'h03FF_FFFF) << 2);
        if (db) return seq + 32'(off);
        return seq;
    endfunction

    // Monitor: pops expectations when a request starts or an instruction is presented
    logic        prev_req = 1'b0, prev_valid = 1'b0;
    logic [31:0] cur_addr = '0, held_instr = '0, held_pc = '0;
    int          run_len = 0, exp_run = 0;
    fetch_exp_t  mon_e;

    always @(negedge clk) begin
        if (reset) begin
            check32("rst_req", 32'(imem.req), 32'd0);
            check32("rst_valid", 32'(instr_valid), 32'd0);
            check32("rst_pc", pc, RESET_PC);
            check32("rst_instr", instr, 32'd0);
            check32("rst_count", instr_count, 32'd0);
            prev_req   = 1'b0;
            prev_valid = 1'b0;
            run_len    = 0;
        end else begin
            if (imem.req && !prev_req) begin
                if (exp_addr_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_req: got addr %h expected no request", imem.addr);
                    cur_addr = imem.addr;
                end else begin
                    cur_addr = exp_addr_q.pop_front();
                    check32("req_addr", imem.addr, cur_addr);
                end
            end
            if (imem.req) begin
                check32("req_addr_stable", imem.addr, cur_addr);
                check32("req_valid_low", 32'(instr_valid), 32'd0);
            end
            if (instr_valid && !prev_valid) begin
                if (exp_fetch_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_valid: got instr %h expected no instruction", instr);
                    held_instr = instr;
                    held_pc    = pc;
                    exp_run    = 0;
                end else begin
                    mon_e = exp_fetch_q.pop_front();
                    check32("instr", instr, mon_e.word);
                    check32("pc", pc, mon_e.pc);
                    check32("pc_plus4", pc_plus4, mon_e.pc + 32'd4);
                    check32("instr_count", instr_count, mon_e.cnt);
                    held_instr = mon_e.word;
                    held_pc    = mon_e.pc;
                    exp_run    = mon_e.run;
                end
                run_len = 0;
            end
            if (instr_valid) begin
                run_len++;
                check32("hold_instr", instr, held_instr);
                check32("hold_pc", pc, held_pc);
                check32("hold_req_low", 32'(imem.req), 32'd0);
            end
            if (!instr_valid && prev_valid)
                check32("valid_cycles", 32'(run_len), 32'(exp_run));
            prev_req   = imem.req;
            prev_valid = instr_valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Decoder/stall inputs the DUT must ignore outside HOLD (or while stalled)
    task automatic junk_inputs();
        stall     = 1'($urandom);
        dobranch  = 1'($urandom);
        dojump    = 1'($urandom);
        jr_target = $urandom;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (imem.req) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL req_timeout: imem_req %0b after 20 cycles expected 1", imem.req);
        end
    endtask

    task automatic do_fetch(input logic [31:0] w, input int ack_dly, input int stall_cyc,
                            input bit db, input bit dj, input logic [31:0] jrt,
                            input bit use_fixed, input logic [31:0] fixed_next);
        fetch_exp_t  e;
        logic [31:0] nxt;
        bit          ok;
        wait_req(ok);
        if (!ok) return;
        for (int i = 0; i < ack_dly; i++) begin
            imem.ack = 1'b0;
            junk_inputs();
            tick();
        end
        imem.ack   = 1'b1;
        imem.rdata = w;
        junk_inputs();
        model_cnt++;
        e.word = w;
        e.pc   = model_pc;
`ifdef IFETCH_PERF_CNT_EN
        e.cnt  = model_cnt;
`else
        e.cnt  = 32'd0;
`endif
        e.run  = stall_cyc + 1;
        exp_fetch_q.push_back(e);
        tick();
        for (int i = 0; i < stall_cyc; i++) begin
            junk_inputs();
            stall      = 1'b1;
            imem.ack   = 1'($urandom);
            imem.rdata = $urandom;
            tick();
        end
        imem.ack  = 1'b0;
        stall     = 1'b0;
        dobranch  = db;
        dojump    = dj;
        jr_target = jrt;
        nxt       = use_fixed ? fixed_next : ref_next(model_pc, w, db, dj, jrt);
        model_pc  = nxt;
        exp_addr_q.push_back(nxt);
        tick();
        dobranch = 1'b0;
        dojump   = 1'b0;
    endtask

    task automatic do_reset(input int cycles, input bit late_ack);
        reset      = 1'b1;
        imem.ack   = late_ack;
        imem.rdata = 32'hDEAD_BEEF;
        stall      = 1'b0;
        dobranch   = 1'b0;
        dojump     = 1'b0;
        exp_addr_q.delete();
        exp_fetch_q.delete();
        model_pc  = RESET_PC;
        model_cnt = 32'd0;
        exp_addr_q.push_back(RESET_PC);
        repeat (cycles) tick();
        reset = 1'b0;
        tick();
        imem.ack = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time %0t expected completion earlier", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit          ok;
        logic [31:0] w;
        reset      = 1'b1;
        stall      = 1'b0;
        dobranch   = 1'b0;
        dojump     = 1'b0;
        jr_target  = '0;
        imem.ack   = 1'b0;
        imem.rdata = '0;
        do_reset(3, 1'b0);

        // Sequential fetches with ack one cycle after each request
        do_fetch(32'h2402_0001, 0, 0, 0, 0, 0, 1, 32'h0040_0004);
        do_fetch(32'h2403_0002, 0, 0, 0, 0, 0, 1, 32'h0040_0008);
        do_fetch(32'h2404_0003, 0, 0, 0, 0, 0, 1, 32'h0040_000C);
`ifdef IFETCH_PERF_CNT_EN
        check32("count_after_3", instr_count, 32'd3);
`else
        check32("count_disabled", instr_count, 32'd0);
`endif
        do_fetch(32'h0000_0020, 1, 0, 0, 0, 0, 1, 32'h0040_0010);
        // Backward branch, jump beats branch, JR drops low target bits
        do_fetch(32'h1000_FFFC, 0, 0, 1, 0, 0, 1, 32'h0040_0004);
        do_fetch(32'h0810_0040, 0, 0, 1, 1, 0, 1, 32'h0040_0100);
        do_fetch(32'h03E0_0008, 0, 0, 0, 0, 32'h0040_0123, 1, 32'h0040_0120);
        // Ack withheld 4 cycles, then stall held 5 cycles in HOLD
        do_fetch(32'h2405_0005, 4, 5, 0, 0, 0, 1, 32'h0040_0124);

        // Reset in the middle of REQ with an ack lingering past release
        wait_req(ok);
        tick();
        do_reset(2, 1'b1);

        // Reach the top of memory via JR, then wrap sequentially
        do_fetch(32'h03E0_0008, 0, 0, 0, 0, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFC);
        do_fetch(32'h2406_0006, 0, 1, 0, 0, 0, 1, 32'h0000_0000);
        do_fetch(32'h2407_0007, 2, 0, 0, 0, 0, 1, 32'h0000_0004);

        for (int n = 0; n < 40; n++) begin
            w = $urandom;
            do_fetch(w, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     1'($urandom), 1'($urandom), $urandom, 1'b0, 32'd0);
        end

        repeat (3) tick();
        check32("addr_queue_drained", 32'(exp_addr_q.size()), 32'd0);
        check32("fetch_queue_drained", 32'(exp_fetch_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
